// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with private HI/LO registers.
// Operands come straight from the GRF read ports (A <- RD1, B <- RD2).
// Optional feature macro: MDU_MADD_EN enables madd (Op 7) and msub (Op 8).
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no operation in flight; accepts issues and mthi/mtlo
// ST_BUSY | mult/div in flight; counter runs down, commit at count 1
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(NMAX + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  logic          is_mul_op;
  logic          is_div_op;
  logic          op_is_div_q;
  logic [63:0]   result;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b;
  logic        [31:0] quo_s;
  logic        [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div_ovf;

  assign Busy = (state == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Classify the incoming opcode: multi-cycle multiply class or divide class.
  always_comb begin
    is_mul_op = 1'b0;
    is_div_op = 1'b0;
    case (Op)
      OP_MULT, OP_MULTU: is_mul_op = 1'b1;
      OP_DIV, OP_DIVU:   is_div_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB:  is_mul_op = 1'b1;
`endif
      default: ;
    endcase
  end

  assign op_is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // Arithmetic on the latched operands; the divisor is forced non-zero so the
  // divider never produces X, the zero case is suppressed at commit instead.
  always_comb begin
    prod_s  = $signed(a_q) * $signed(b_q);
    prod_u  = {32'b0, a_q} * {32'b0, b_q};
    div_b   = (b_q == 32'b0) ? 32'd1 : b_q;
    div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    quo_s   = $signed(a_q) / $signed(div_b);
    rem_s   = $signed(a_q) % $signed(div_b);
    quo_u   = a_q / div_b;
    rem_u   = a_q % div_b;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'b0;
    end
  end

  // Select the 64-bit {HI,LO} value to commit for the in-flight operation.
  always_comb begin
    result = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = {rem_s, quo_s};
      OP_DIVU:  result = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi_q, lo_q} + prod_s;
      OP_MSUB:  result = {hi_q, lo_q} - prod_s;
`endif
      default: ;
    endcase
  end

  // Issue, countdown and commit; HI/LO only change on commit or mthi/mtlo.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (is_mul_op || is_div_op) begin
              state <= ST_BUSY;
              op_q  <= Op;
              a_q   <= A;
              b_q   <= B;
              cnt   <= is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (Op == OP_MTHI) begin
              hi_q <= A;
            end else if (Op == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        default: begin
          if (cnt == CW'(1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (!(op_is_div_q && (b_q == 32'b0))) begin
              hi_q <= result[63:32];
              lo_q <= result[31:0];
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors for mdu_unit; expected HI/LO and Busy length are
// queued at issue time and checked by a monitor when Busy falls.
module tb_mdu_unit;

  logic        clk;
  logic        Reset;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.hi = hi; e.lo = lo; e.cyc = cyc; e.name = name;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; Op = 4'd0; A = 32'd0; B = 32'd0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 50 && Busy; i++) @(negedge clk);
    if (Busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: Busy still 1 after 50 cycles, expected 0", name);
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: counts Busy-high samples and checks HI/LO plus duration on Busy fall.
  initial begin : monitor
    logic prev;
    int   cnt;
    exp_t e;
    prev = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (!Reset) begin
        prev = 1'b0;
        cnt  = 0;
      end else begin
        if (Busy) begin
          cnt++;
        end else if (prev) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_commit: Busy fell after %0d cycles, no issue pending", cnt);
          end else begin
            e = sb.pop_front();
            check({e.name, "_busy_cycles"}, 32'(cnt), 32'(e.cyc));
            check({e.name, "_hi"}, HI, e.hi);
            check({e.name, "_lo"}, LO, e.lo);
          end
          cnt = 0;
        end
        prev = Busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    Reset = 1'b0; Start = 1'b0; Op = 4'd0; A = 32'd0; B = 32'd0;
    #12;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    @(negedge clk);
    Reset = 1'b1;
    repeat (2) @(negedge clk);

    push("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult_neg");

    // Abort a div in its third cycle; reset must clear everything at once.
    issue(4'd3, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #2 Reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(posedge clk);
    #2 Reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post_abort_hi", HI, 32'd0);
    check("post_abort_lo", LO, 32'd0);

    push("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle("multu");

    push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg");

    push("divu", 32'd1, 32'd3, 10);
    issue(4'd4, 32'd7, 32'd2);
    wait_idle("divu");

    push("div_ovf", 32'd0, 32'h8000_0000, 10);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    issue(4'd6, 32'h0000_1234, 32'd0);
    check("mtlo_busy", {31'd0, Busy}, 32'd0);
    check("mtlo_lo", LO, 32'h0000_1234);
    check("mtlo_hi", HI, 32'd0);

    push("div_by_zero", 32'd0, 32'h0000_1234, 10);
    issue(4'd3, 32'd5, 32'd0);
    wait_idle("div_by_zero");

    // Second mult and mthi land while busy and must both be dropped.
    push("mult_ignore", 32'd0, 32'd6, 5);
    issue(4'd1, 32'd2, 32'd3);
    issue(4'd1, 32'd9, 32'd9);
    issue(4'd5, 32'h0000_DEAD, 32'd0);
    wait_idle("mult_ignore");

    issue(4'd5, 32'h0000_ABCD, 32'd0);
    check("mthi_hi", HI, 32'h0000_ABCD);
    check("mthi_lo", LO, 32'd6);

    hold_hi = HI;
    hold_lo = LO;
    issue(4'd0, 32'h1111_1111, 32'h2222_2222);
    issue(4'd9, 32'h3333_3333, 32'h4444_4444);
    issue(4'd15, 32'h5555_5555, 32'd1);
`ifndef MDU_MADD_EN
    issue(4'd7, 32'd1, 32'd1);
    issue(4'd8, 32'd1, 32'd1);
`endif
    @(negedge clk);
    check("unused_busy", {31'd0, Busy}, 32'd0);
    check("unused_hi", HI, hold_hi);
    check("unused_lo", LO, hold_lo);

`ifdef MDU_MADD_EN
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    push("madd", 32'd1, 32'd0, 5);
    issue(4'd7, 32'd1, 32'd1);
    wait_idle("madd");
    push("msub", 32'd0, 32'hFFFF_FFFF, 5);
    issue(4'd8, 32'd1, 32'd1);
    wait_idle("msub");
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
